// File: rtl/mau_pkg.sv
// mau_pkg -- shared definitions for the memory access unit.
//   * SZ_B/SZ_H/SZ_W/SZ_D : request size encodings (byte/half/word/dword)
//   * state_e             : access FSM states
//   * misaligned()        : alignment / legality check applied at handshake
package mau_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LD_DATA,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    // Address must be aligned to 2^size; dword accesses are illegal on a 32-bit datapath.
    function automatic logic misaligned(input logic [2:0]  addr_lo,
                                        input logic [1:0]  size,
                                        input int unsigned xlen);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return (xlen == 32) || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane -- combinational lane extraction and store merge.
// Ports:
//   word_i     : memory word (read data)
//   offset_i   : byte offset of the access within the word
//   size_i     : access size (SZ_B..SZ_D)
//   unsigned_i : zero-extend (1) or sign-extend (0) load data
//   wdata_i    : right-aligned store data
//   ld_data_o  : extended load value
//   st_merge_o : word_i with the addressed lane replaced by wdata_i
module mau_lane
    import mau_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  ld_data_o,
    output logic [XLEN-1:0]  st_merge_o
);

    logic [6:0]       lane_w;
    logic [OFF_W+2:0] lane_lo;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep;
    logic [XLEN-1:0]  lane_mask;
    logic             sign;

    always_comb begin
        lane_w  = 7'd8 << size_i;
        lane_lo = {offset_i, 3'b000};
        shifted = word_i >> lane_lo;
        // Shifting by >= XLEN yields zero, so a full-width lane keeps every bit.
        keep    = ~({XLEN{1'b1}} << lane_w);
        case (size_i)
            SZ_B:    sign = shifted[7];
            SZ_H:    sign = shifted[15];
            SZ_W:    sign = shifted[31];
            default: sign = shifted[XLEN-1];
        endcase
        ld_data_o  = (shifted & keep) | (~keep & {XLEN{~unsigned_i & sign}});
        lane_mask  = keep << lane_lo;
        st_merge_o = (word_i & ~lane_mask) | ((wdata_i << lane_lo) & lane_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- sub-word load/store unit in front of a single-port
// synchronous data memory (read data valid one cycle after the read).
// Optional feature macro: MAU_BYTE_STROBE_EN (sub-word stores use byte strobes
// in a single write instead of a read-modify-write).
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake (ready only when idle)
//   req_we/size/unsigned/addr/wdata: request fields, latched on handshake
//   resp_valid/resp_ready          : response handshake
//   resp_rdata/resp_err            : extended load data (0 for stores/errors), error flag
//   mem_en/we/wstrb/addr/wdata     : memory command, decoded from state and latched request
//   mem_rdata                      : memory read data
module mem_access_unit
    import mau_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned OFF_W  = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_e              state_q, state_d;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [XLEN-1:0]     ld_data;
    logic [XLEN-1:0]     st_merge;
    logic                full_w;

    mau_lane #(.XLEN(XLEN)) u_lane (
        .word_i     (mem_rdata),
        .offset_i   (addr_q[OFF_W-1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_merge_o (st_merge)
    );

    assign full_w     = (size_q == 2'(OFF_W));
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef MAU_BYTE_STROBE_EN
    logic [XLEN/8-1:0] strb_sub;
    logic [XLEN-1:0]   wdata_rep;

    always_comb begin
        strb_sub = ~({(XLEN/8){1'b1}} << (4'd1 << size_q)) << addr_q[OFF_W-1:0];
        case (size_q)
            SZ_B:    wdata_rep = {(XLEN/8){wdata_q[7:0]}};
            SZ_H:    wdata_rep = {(XLEN/16){wdata_q[15:0]}};
            default: wdata_rep = {(XLEN/32){wdata_q[31:0]}};
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_wstrb  = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    err_d   = misaligned(req_addr[2:0], req_size, XLEN);
                    rdata_d = '0;
                    state_d = err_d ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                if (!we_q) begin
                    state_d = ST_LD_DATA;
                end else if (full_w) begin
                    mem_we    = 1'b1;
                    mem_wstrb = '1;
                    mem_wdata = wdata_q;
                    state_d   = ST_RESP;
                end else begin
`ifdef MAU_BYTE_STROBE_EN
                    mem_we    = 1'b1;
                    mem_wstrb = strb_sub;
                    mem_wdata = wdata_rep;
                    state_d   = ST_RESP;
`else
                    // Read half of the RMW; merged write follows in ST_RMW_WR.
                    state_d   = ST_RMW_WR;
`endif
                end
            end
            ST_LD_DATA: begin
                rdata_d = ld_data;
                state_d = ST_RESP;
            end
            ST_RMW_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wstrb = '1;
                mem_wdata = st_merge;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one 32-bit and one 64-bit instance,
// each attached to a small behavioural synchronous memory.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- 32-bit instance ----------------
    logic        a_valid = 0, a_ready, a_we = 0, a_uns = 0, a_rvalid, a_rready = 0, a_err;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_rdata, a_maddr, a_mwdata, a_mrdata = 0;
    logic        a_men, a_mwe;
    logic [3:0]  a_wstrb;

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rstn(rstn),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_size(a_size),
        .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_rvalid), .resp_ready(a_rready), .resp_rdata(a_rdata), .resp_err(a_err),
        .mem_en(a_men), .mem_we(a_mwe), .mem_wstrb(a_wstrb), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
    );

    logic [31:0] mem_a [0:15] = '{1: 32'h80FF_1234, default: 32'h0};
    int a_rd = 0, a_wr = 0, a_en = 0;
    logic [31:0] a_last_wdata = 0, a_last_addr = 0;
    logic [3:0]  a_last_strb = 0;

    always @(posedge clk) begin
        if (a_men) begin
            a_en <= a_en + 1;
            if (a_mwe) begin
                a_wr         <= a_wr + 1;
                a_last_wdata <= a_mwdata;
                a_last_addr  <= a_maddr;
                a_last_strb  <= a_wstrb;
                for (int b = 0; b < 4; b++)
                    if (a_wstrb[b]) mem_a[a_maddr[5:2]][b*8 +: 8] <= a_mwdata[b*8 +: 8];
            end else begin
                a_rd     <= a_rd + 1;
                a_mrdata <= mem_a[a_maddr[5:2]];
            end
        end
    end

    // ---------------- 64-bit instance ----------------
    logic        b_valid = 0, b_ready, b_we = 0, b_uns = 0, b_rvalid, b_rready = 0, b_err;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0, b_maddr;
    logic [63:0] b_wdata = 0, b_rdata, b_mwdata, b_mrdata = 0;
    logic        b_men, b_mwe;
    logic [7:0]  b_wstrb;

    mem_access_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rstn(rstn),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
        .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_rvalid), .resp_ready(b_rready), .resp_rdata(b_rdata), .resp_err(b_err),
        .mem_en(b_men), .mem_we(b_mwe), .mem_wstrb(b_wstrb), .mem_addr(b_maddr),
        .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
    );

    logic [63:0] mem_b [0:7] = '{1: 64'hDEAD_BEEF_0123_4567, default: 64'h0};

    always @(posedge clk) begin
        if (b_men) begin
            if (b_mwe) begin
                for (int b = 0; b < 8; b++)
                    if (b_wstrb[b]) mem_b[b_maddr[5:3]][b*8 +: 8] <= b_mwdata[b*8 +: 8];
            end else begin
                b_mrdata <= mem_b[b_maddr[5:3]];
            end
        end
    end

    // One full transaction; lat counts cycles from the handshake edge to resp_valid.
    task automatic req_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        while (!a_rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = a_rdata;
        err   = a_err;
        a_rready = 1'b1;
        @(posedge clk); #1;
        a_rready = 1'b0;
    endtask

    task automatic req_b(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err, output int lat);
        @(negedge clk);
        b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = 1;
        while (!b_rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = b_rdata;
        err   = b_err;
        b_rready = 1'b1;
        @(posedge clk); #1;
        b_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] rd64;
        logic        er;
        int          lat, rd0, wr0, en0;

        // Reset state
        #12;
        check("rst_resp_valid", a_rvalid, 0);
        check("rst_resp_rdata", a_rdata, 0);
        check("rst_resp_err",   a_err, 0);
        check("rst_mem_en",     a_men, 0);
        check("rst_mem_we",     a_mwe, 0);
        check("rst_mem_wstrb",  a_wstrb, 0);
        check("rst_mem_en64",   b_men, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("idle_req_ready", a_ready, 1);

        // Byte/half loads from 0x80FF_1234 at 0x4
        req_a(0, SZ_B, 0, 32'h5, 0, rd, er, lat);
        check("lb5_data", rd, 32'h0000_0012);
        check("lb5_lat",  lat, 3);
        check("lb5_err",  er, 0);
        req_a(0, SZ_B, 0, 32'h7, 0, rd, er, lat);
        check("lb7_data", rd, 32'hFFFF_FF80);
        req_a(0, SZ_B, 1, 32'h7, 0, rd, er, lat);
        check("lbu7_data", rd, 32'h0000_0080);
        req_a(0, SZ_H, 0, 32'h6, 0, rd, er, lat);
        check("lh6_data", rd, 32'hFFFF_80FF);

        // Byte store 0xAB to 0x6
        rd0 = a_rd; wr0 = a_wr;
        req_a(1, SZ_B, 0, 32'h6, 32'h0000_00AB, rd, er, lat);
        check("sb6_err",   er, 0);
        check("sb6_rdata", rd, 0);
        check("sb6_waddr", a_last_addr, 32'h4);
        check("sb6_nwr",   64'(a_wr - wr0), 1);
`ifdef MAU_BYTE_STROBE_EN
        check("sb6_lat",   lat, 2);
        check("sb6_nrd",   64'(a_rd - rd0), 0);
        check("sb6_strb",  a_last_strb, 4'b0100);
        check("sb6_byte2", a_last_wdata[23:16], 8'hAB);
`else
        check("sb6_lat",   lat, 3);
        check("sb6_nrd",   64'(a_rd - rd0), 1);
        check("sb6_strb",  a_last_strb, 4'hF);
        check("sb6_wdata", a_last_wdata, 32'h80AB_1234);
`endif
        req_a(0, SZ_W, 0, 32'h4, 0, rd, er, lat);
        check("lw4_after_sb", rd, 32'h80AB_1234);

        // Error cases: no memory access at all
        en0 = a_en;
        req_a(0, SZ_H, 0, 32'h3, 0, rd, er, lat);
        check("lh3_err",   er, 1);
        check("lh3_rdata", rd, 0);
        check("lh3_lat",   lat, 1);
        check("lh3_no_en", 64'(a_en - en0), 0);
        req_a(0, SZ_D, 0, 32'h0, 0, rd, er, lat);
        check("ld32_err",  er, 1);
        check("ld32_lat",  lat, 1);

        // Full-width store
        req_a(1, SZ_W, 0, 32'h8, 32'h1122_3344, rd, er, lat);
        check("sw8_lat",   lat, 2);
        check("sw8_err",   er, 0);
        check("sw8_strb",  a_last_strb, 4'hF);
        check("sw8_wdata", a_last_wdata, 32'h1122_3344);
        check("sw8_waddr", a_last_addr, 32'h8);

        // Response held while resp_ready stays low
        @(negedge clk);
        a_we = 0; a_size = SZ_B; a_uns = 1; a_addr = 32'h8; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        while (!a_rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", a_rvalid, 1);
            check("hold_rdata", a_rdata, 32'h44);
            check("hold_ready", a_ready, 0);
            @(posedge clk); #1;
        end
        a_rready = 1'b1;
        @(posedge clk); #1;
        a_rready = 1'b0;
        check("hold_released", a_rvalid, 0);

        // Half store then readback
        req_a(1, SZ_H, 0, 32'hA, 32'h0000_BEEF, rd, er, lat);
        req_a(0, SZ_W, 0, 32'h8, 0, rd, er, lat);
        check("sh_readback", rd, 32'hBEEF_3344);

        // Reset during the write phase of a sub-word store
        wr0 = a_wr;
        @(negedge clk);
        a_we = 1; a_size = SZ_B; a_uns = 0; a_addr = 32'h4; a_wdata = 32'h77; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
`ifndef MAU_BYTE_STROBE_EN
        @(posedge clk); #1;
`endif
        check("abort_we_before", a_mwe, 1);
        rstn = 1'b0;
        #1;
        check("abort_mem_en",     a_men, 0);
        check("abort_mem_we",     a_mwe, 0);
        check("abort_mem_wstrb",  a_wstrb, 0);
        check("abort_resp_valid", a_rvalid, 0);
        check("abort_resp_rdata", a_rdata, 0);
        check("abort_resp_err",   a_err, 0);
        @(posedge clk); @(posedge clk); #1;
        check("abort_no_write", 64'(a_wr - wr0), 0);
        check("abort_mem_word", mem_a[1], 32'h80AB_1234);
        @(negedge clk);
        rstn = 1'b1;

        // 64-bit datapath, word 0xDEAD_BEEF_0123_4567 at 0x8
        req_b(0, SZ_W, 0, 32'hC, 0, rd64, er, lat);
        check("x64_lw_c",   rd64, 64'hFFFF_FFFF_DEAD_BEEF);
        check("x64_lw_lat", lat, 3);
        req_b(0, SZ_H, 1, 32'hA, 0, rd64, er, lat);
        check("x64_lhu_a",  rd64, 64'h0000_0000_0000_0123);
        req_b(0, SZ_D, 0, 32'h8, 0, rd64, er, lat);
        check("x64_ld_8",   rd64, 64'hDEAD_BEEF_0123_4567);
        check("x64_ld_err", er, 0);
        req_b(1, SZ_B, 0, 32'hF, 64'h5A, rd64, er, lat);
`ifdef MAU_BYTE_STROBE_EN
        check("x64_sb_lat", lat, 2);
`else
        check("x64_sb_lat", lat, 3);
`endif
        req_b(0, SZ_D, 0, 32'h8, 0, rd64, er, lat);
        check("x64_sb_readback", rd64, 64'h5AAD_BEEF_0123_4567);
        req_b(0, SZ_B, 0, 32'hF, 0, rd64, er, lat);
        check("x64_lb_f", rd64, 64'h5A);
        req_b(0, SZ_W, 0, 32'hA, 0, rd64, er, lat);
        check("x64_lw_a_err", er, 1);
        check("x64_lw_a_lat", lat, 1);
        req_b(1, SZ_D, 0, 32'h10, 64'h0011_2233_4455_6677, rd64, er, lat);
        check("x64_sd_lat", lat, 2);
        req_b(0, SZ_W, 1, 32'h14, 0, rd64, er, lat);
        check("x64_lwu_14", rd64, 64'h0000_0000_0011_2233);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
